// File: rtl/seq_player.sv
// rtl/seq_player.sv - steps through one sequence of the pattern ROM, one step per slow_clk rise
module seq_player #(
  parameter int SEQ_BITS  = 3,
  parameter int STEP_BITS = 4,
  parameter int DATA_W    = 8,
  localparam int ADDR_W   = SEQ_BITS + STEP_BITS
) (
  input  logic                 clk_50,
  input  logic                 reset,
  input  logic                 slow_clk,
  input  logic                 run,
  input  logic                 loop_en,
  input  logic [SEQ_BITS-1:0]  seq_num,
  input  logic [DATA_W:0]      rom_data,
  output logic [ADDR_W-1:0]    rom_addr,
  output logic [DATA_W-1:0]    pattern_out,
  output logic [STEP_BITS-1:0] step_num,
  output logic                 busy,
  output logic                 seq_done
);

  typedef enum logic [2:0] {S_IDLE, S_FETCH, S_WAIT, S_HOLD, S_DONE} state_t;

  state_t               state_q, state_d;
  logic [2:0]           sync_q;
  logic [SEQ_BITS-1:0]  seq_q, seq_d;
  logic [STEP_BITS-1:0] step_q, step_d;
  logic                 last_q, last_d;
  logic [ADDR_W-1:0]    addr_q, addr_d;
  logic [DATA_W-1:0]    pat_q, pat_d;
  logic [STEP_BITS-1:0] stepn_q, stepn_d;
  logic                 done_q, done_d;
  logic                 tick;
  logic                 is_last;
  logic [STEP_BITS-1:0] step_inc;

  // sync_q[1:0] is the two-flop synchroniser, sync_q[2] the edge-detect history
  assign tick     = sync_q[1] & ~sync_q[2];
  assign is_last  = last_q | (&step_q);
  assign step_inc = step_q + STEP_BITS'(1);

  always_ff @(posedge clk_50 or posedge reset) begin
    if (reset) begin
      state_q <= S_IDLE;
      sync_q  <= '0;
      seq_q   <= '0;
      step_q  <= '0;
      last_q  <= 1'b0;
      addr_q  <= '0;
      pat_q   <= '0;
      stepn_q <= '0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      sync_q  <= {sync_q[1:0], slow_clk};
      seq_q   <= seq_d;
      step_q  <= step_d;
      last_q  <= last_d;
      addr_q  <= addr_d;
      pat_q   <= pat_d;
      stepn_q <= stepn_d;
      done_q  <= done_d;
    end
  end

  always_comb begin
    state_d = state_q;
    seq_d   = seq_q;
    step_d  = step_q;
    last_d  = last_q;
    addr_d  = addr_q;
    pat_d   = pat_q;
    stepn_d = stepn_q;
    done_d  = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (run) begin
          seq_d   = seq_num;
          step_d  = '0;
          addr_d  = {seq_num, {STEP_BITS{1'b0}}};
          state_d = S_FETCH;
        end
      end
      S_FETCH, S_WAIT, S_HOLD: begin
        // Abort wins over everything, including a tick on the same edge
        if (!run) begin
          state_d = S_IDLE;
          pat_d   = '0;
          stepn_d = '0;
        end else if (state_q == S_FETCH) begin
          state_d = S_WAIT;
        end else if (state_q == S_WAIT) begin
          pat_d   = rom_data[DATA_W-1:0];
          last_d  = rom_data[DATA_W];
          stepn_d = step_q;
          state_d = S_HOLD;
        end else if (tick) begin
          if (!is_last) begin
            step_d  = step_inc;
            addr_d  = {seq_q, step_inc};
            state_d = S_FETCH;
          end else if (loop_en) begin
            seq_d   = seq_num;
            step_d  = '0;
            addr_d  = {seq_num, {STEP_BITS{1'b0}}};
            state_d = S_FETCH;
          end else begin
            done_d  = 1'b1;
            state_d = S_DONE;
          end
        end
      end
      S_DONE: begin
        if (!run) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  assign rom_addr    = addr_q;
  assign pattern_out = pat_q;
  assign step_num    = stepn_q;
  assign seq_done    = done_q;
  assign busy        = (state_q == S_FETCH) || (state_q == S_WAIT) || (state_q == S_HOLD);

endmodule
